// File: rtl/data_mem_responder_pkg.sv
// rtl/data_mem_responder_pkg.sv - shared state encoding and data width for the data memory responder
package data_mem_responder_pkg;

    localparam int DATA_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

endpackage

// File: rtl/data_mem_array.sv
// rtl/data_mem_array.sv - DEPTH x 16 register array, synchronous write, asynchronous read
module data_mem_array
    import data_mem_responder_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_idx,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic [$clog2(DEPTH)-1:0] rd_idx,
    output logic [DATA_W-1:0]        rd_data
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];

    // Next contents: hold every word, overwrite the addressed one on a write.
    always_comb begin
        mem_d = mem_q;
        if (wr_en) begin
            mem_d[wr_idx] = wr_data;
        end
    end

    // Storage; reset clears every word so loads after reset return zero.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    assign rd_data = mem_q[rd_idx];

endmodule

// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - fixed-latency load/store responder in front of a small data memory
module data_mem_responder
    import data_mem_responder_pkg::*;
#(
    parameter int DEPTH       = 8,
    parameter int WAIT_STATES = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req_valid,
    input  logic              req_write,
    input  logic [DATA_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              req_ready,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err
);

    localparam int          AW        = $clog2(DEPTH);
    localparam logic [3:0]  WAIT_LOAD = 4'(WAIT_STATES);
    localparam logic [15:0] DEPTH_W   = 16'(DEPTH);

    state_e            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              wr_q, wr_d;
    logic [DATA_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
    logic              rsp_err_q, rsp_err_d;

    logic              in_range;
    logic              mem_we;
    logic [DATA_W-1:0] mem_rdata;

    assign in_range = (addr_q < DEPTH_W);

    data_mem_array #(
        .DEPTH(DEPTH)
    ) u_array (
        .clk     (clk),
        .reset_n (reset_n),
        .wr_en   (mem_we),
        .wr_idx  (addr_q[AW-1:0]),
        .wr_data (wdata_q),
        .rd_idx  (addr_q[AW-1:0]),
        .rd_data (mem_rdata)
    );

    // Next state, wait counter and response. The response is registered out of
    // RESP, so rsp_valid is seen in the cycle after RESP while the FSM is back in
    // IDLE; that is what makes the spacing WAIT_STATES + 2.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        wr_d        = wr_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = '0;
        rsp_err_d   = 1'b0;
        mem_we      = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    wr_d    = req_write;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    cnt_d   = WAIT_LOAD;
                    state_d = (WAIT_STATES == 0) ? RESP : WAIT;
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                state_d     = IDLE;
                rsp_valid_d = 1'b1;
                if (!in_range) begin
                    rsp_err_d = 1'b1;
                end else if (wr_q) begin
                    mem_we = 1'b1;
                end else begin
                    rsp_rdata_d = mem_rdata;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and response registers; reset abandons any in-flight request.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            wr_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            wr_q        <= wr_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign req_ready = (state_q == IDLE);
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// tb/tb_data_mem_responder.sv - self-checking bench for data_mem_responder (WAIT_STATES 2 and 0)
module tb_data_mem_responder;

    logic        clk = 1'b0;
    logic        rn  [2];
    logic        rv  [2];
    logic        rw  [2];
    logic [15:0] ra  [2];
    logic [15:0] rwd [2];
    logic        ready [2];
    logic        vld   [2];
    logic [15:0] rd    [2];
    logic        err   [2];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    data_mem_responder #(.DEPTH(8), .WAIT_STATES(2)) dut (
        .clk(clk), .reset_n(rn[0]), .req_valid(rv[0]), .req_write(rw[0]),
        .req_addr(ra[0]), .req_wdata(rwd[0]), .req_ready(ready[0]),
        .rsp_valid(vld[0]), .rsp_rdata(rd[0]), .rsp_err(err[0])
    );

    data_mem_responder #(.DEPTH(8), .WAIT_STATES(0)) dut0 (
        .clk(clk), .reset_n(rn[1]), .req_valid(rv[1]), .req_write(rw[1]),
        .req_addr(ra[1]), .req_wdata(rwd[1]), .req_ready(ready[1]),
        .rsp_valid(vld[1]), .rsp_rdata(rd[1]), .rsp_err(err[1])
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Behavioural model: one outstanding request at most; its response is due
    // WAIT_STATES+1 edges after the accept edge, and a store lands in memory then.
    int          wait_of [2] = '{2, 0};
    int          edge_cnt [2] = '{0, 0};
    bit          pend [2] = '{0, 0};
    int          due [2];
    bit          p_write [2];
    logic [15:0] p_addr [2];
    logic [15:0] p_wdata [2];
    logic [15:0] mem [2][8];
    bit          m_valid [2] = '{0, 0};
    logic [15:0] m_rdata [2] = '{16'h0, 16'h0};
    bit          m_err [2] = '{0, 0};
    int          accepts [2] = '{0, 0};

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            m_valid[i] = 1'b0;
            m_rdata[i] = 16'h0;
            m_err[i]   = 1'b0;
            if (!rn[i]) begin
                pend[i] = 1'b0;
                for (int j = 0; j < 8; j++) mem[i][j] = 16'h0;
            end else begin
                edge_cnt[i]++;
                if (pend[i]) begin
                    if (edge_cnt[i] == due[i]) begin
                        pend[i]    = 1'b0;
                        m_valid[i] = 1'b1;
                        if (p_addr[i] >= 16'd8) m_err[i] = 1'b1;
                        else if (p_write[i]) mem[i][p_addr[i][2:0]] = p_wdata[i];
                        else m_rdata[i] = mem[i][p_addr[i][2:0]];
                    end
                end else if (rv[i]) begin
                    pend[i]    = 1'b1;
                    due[i]     = edge_cnt[i] + 1 + wait_of[i];
                    p_write[i] = rw[i];
                    p_addr[i]  = ra[i];
                    p_wdata[i] = rwd[i];
                    accepts[i]++;
                end
            end
        end
    end

    // Every-cycle comparison of both DUTs against the model.
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (!rn[i]) begin
                chk($sformatf("dut%0d req_ready in reset", i), 32'(ready[i]), 32'd1);
                chk($sformatf("dut%0d rsp_valid in reset", i), 32'(vld[i]), 32'd0);
                chk($sformatf("dut%0d rsp_rdata in reset", i), 32'(rd[i]), 32'd0);
                chk($sformatf("dut%0d rsp_err in reset", i), 32'(err[i]), 32'd0);
            end else begin
                chk($sformatf("dut%0d req_ready", i), 32'(ready[i]), 32'(!pend[i]));
                chk($sformatf("dut%0d rsp_valid", i), 32'(vld[i]), 32'(m_valid[i]));
                chk($sformatf("dut%0d rsp_rdata", i), 32'(rd[i]), 32'(m_rdata[i]));
                chk($sformatf("dut%0d rsp_err", i), 32'(err[i]), 32'(m_err[i]));
            end
        end
    end

    task automatic wait_rsp(input int i, output logic [15:0] data, output logic e, output int lat);
        data = 16'h0;
        e    = 1'b0;
        lat  = -1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (vld[i]) begin
                data = rd[i];
                e    = err[i];
                lat  = k;
                break;
            end
        end
    endtask

    task automatic xact(input int i, input logic w, input logic [15:0] a, input logic [15:0] d,
                        output logic [15:0] data, output logic e, output int lat);
        @(posedge clk); #2;
        rv[i] = 1'b1; rw[i] = w; ra[i] = a; rwd[i] = d;
        @(posedge clk); #2;
        rv[i] = 1'b0;
        wait_rsp(i, data, e, lat);
    endtask

    logic [15:0] data;
    logic        e;
    int          lat;
    int          dut_acc;
    int          acc0;
    int          vcount;

    initial begin
        for (int i = 0; i < 2; i++) begin
            rn[i] = 1'b0; rv[i] = 1'b0; rw[i] = 1'b0; ra[i] = 16'h0; rwd[i] = 16'h0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset req_ready", 32'(ready[0]), 32'd1);
        chk("reset rsp_valid", 32'(vld[0]), 32'd0);

        // Release reset with a load already presented: accepted at the first edge.
        @(posedge clk); #2;
        rn[0] = 1'b1; rn[1] = 1'b1;
        rv[0] = 1'b1; rw[0] = 1'b0; ra[0] = 16'd5;
        @(posedge clk); #2;
        rv[0] = 1'b0;
        wait_rsp(0, data, e, lat);
        chk("first load latency", 32'(lat), 32'd3);
        chk("load addr5 after reset", 32'(data), 32'h0000);

        xact(0, 1'b1, 16'd3, 16'hBEEF, data, e, lat);
        chk("store latency", 32'(lat), 32'd3);
        chk("store err", 32'(e), 32'd0);
        xact(0, 1'b0, 16'd3, 16'h0, data, e, lat);
        chk("load latency", 32'(lat), 32'd3);
        chk("load addr3 data", 32'(data), 32'hBEEF);
        chk("load addr3 err", 32'(e), 32'd0);

        xact(0, 1'b1, 16'd8, 16'h1234, data, e, lat);
        chk("oor store err", 32'(e), 32'd1);
        chk("oor store rdata", 32'(data), 32'h0);
        for (int a = 0; a < 8; a++) begin
            xact(0, 1'b0, 16'(a), 16'h0, data, e, lat);
            chk($sformatf("after oor load addr%0d", a), 32'(data), (a == 3) ? 32'hBEEF : 32'h0);
        end

        // Continuous req_valid with addresses 1,2,3 advancing every 4 cycles.
        acc0    = accepts[0];
        dut_acc = 0;
        @(posedge clk); #2;
        rv[0] = 1'b1; rw[0] = 1'b0; ra[0] = 16'd1;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (ready[0]) dut_acc++;
            @(posedge clk); #2;
            ra[0] = 16'(1 + ((k + 1) / 4) % 3);
        end
        rv[0] = 1'b0;
        chk("busy dut accepts", 32'(dut_acc), 32'd3);
        chk("busy model accepts", 32'(accepts[0] - acc0), 32'd3);
        repeat (6) @(posedge clk);

        // Reset during WAIT of a store: no response, no write.
        @(posedge clk); #2;
        rv[0] = 1'b1; rw[0] = 1'b1; ra[0] = 16'd2; rwd[0] = 16'hAAAA;
        @(posedge clk); #2;
        rv[0] = 1'b0;
        @(posedge clk); #2;
        rn[0] = 1'b0;
        vcount = 0;
        repeat (4) begin @(negedge clk); if (vld[0]) vcount++; end
        @(posedge clk); #2;
        rn[0] = 1'b1;
        repeat (4) begin @(negedge clk); if (vld[0]) vcount++; end
        chk("midreset no rsp_valid", 32'(vcount), 32'd0);
        xact(0, 1'b0, 16'd2, 16'h0, data, e, lat);
        chk("midreset load addr2", 32'(data), 32'h0000);

        // Zero wait states.
        xact(1, 1'b0, 16'd0, 16'h0, data, e, lat);
        chk("w0 load latency", 32'(lat), 32'd1);
        chk("w0 load data", 32'(data), 32'h0);
        xact(1, 1'b1, 16'd7, 16'h5A5A, data, e, lat);
        chk("w0 store latency", 32'(lat), 32'd1);
        xact(1, 1'b0, 16'd7, 16'h0, data, e, lat);
        chk("w0 load addr7", 32'(data), 32'h5A5A);
        xact(1, 1'b1, 16'hFFFF, 16'h1111, data, e, lat);
        chk("w0 oor err", 32'(e), 32'd1);

        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
